// File: rtl/if_prefetch.sv
// Instruction-fetch stage: one-outstanding sequential fetcher over a req/ack memory port,
// feeding a DEPTH-entry {pc, inst} queue that decode drains; an ID branch flushes everything.
module if_prefetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic [INST_W-1:0]        mem_rdata_i,
  input  logic                     branch_flag_i,
  input  logic [ADDR_W-1:0]        branch_addr_i,
  output logic                     inst_valid_o,
  output logic [INST_W-1:0]        inst_o,
  output logic [ADDR_W-1:0]        pc_o,
  input  logic                     id_ready_i,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [1:0]               state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n, addr_n;
  logic [ADDR_W-1:0] branch_tgt, next_seq;

  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [INST_W-1:0] q_inst [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count, count_n;
  logic              push, pop, room;

  // Handshakes: memory transfers when mem_req_o & mem_ack_i; mem_addr_o holds until then.
  // Decode transfers when inst_valid_o & id_ready_i, unless a branch flushes that cycle.
  always_comb begin
    branch_tgt = branch_addr_i & ~ADDR_W'(3);
    next_seq   = mem_addr_o + ADDR_W'(4);
    pop        = inst_valid_o & id_ready_i & ~branch_flag_i;
    push       = (state == REQ) & mem_ack_i & ~branch_flag_i;
    count_n    = branch_flag_i ? '0 : count + CW'(push) - CW'(pop);
    room       = (count_n < DEPTH_C);
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = mem_addr_o;
    case (state)
      IDLE: begin
        if (branch_flag_i) begin
          fetch_pc_n = branch_tgt;
          addr_n     = branch_tgt;
          state_n    = REQ;
        end else if (room) begin
          addr_n  = fetch_pc;
          state_n = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          if (branch_flag_i) begin
            fetch_pc_n = branch_tgt;
            addr_n     = branch_tgt;
          end else begin
            fetch_pc_n = next_seq;
            if (room) addr_n = next_seq;
            else      state_n = IDLE;
          end
        end else if (branch_flag_i) begin
          // The pending address must stay on the bus until the memory acks it.
          fetch_pc_n = branch_tgt;
          state_n    = DROP;
        end
      end
      DROP: begin
        if (branch_flag_i) fetch_pc_n = branch_tgt;
        if (mem_ack_i) begin
          state_n = REQ;
          addr_n  = branch_flag_i ? branch_tgt : fetch_pc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      fetch_pc   <= RESET_PC;
      mem_addr_o <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      state      <= state_n;
      mem_req_o  <= (state_n != IDLE);
      fetch_pc   <= fetch_pc_n;
      mem_addr_o <= addr_n;
      count      <= count_n;
      if (branch_flag_i) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      q_pc[tail]   <= mem_addr_o;
      q_inst[tail] <= mem_rdata_i;
    end
  end

  always_comb begin
    inst_valid_o = (count != '0);
    inst_o       = inst_valid_o ? q_inst[head] : '0;
    pc_o         = inst_valid_o ? q_pc[head] : '0;
    occupancy_o  = count;
    state_o      = state;
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch stage with a prefetch queue. It replaces the bare PC register and the IF/ID latch in front of decode. It fetches sequential instructions from instruction memory over a req/ack handshake that tolerates wait states. Fetched {pc, inst} pairs are buffered in a DEPTH-entry FIFO, and decode pulls them with a valid/ready handshake. A branch redirect from ID flushes the queue and discards any in-flight fetch.

## Interface
- ADDR_W, 32, instruction address width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- mem_req_o  out  1  fetch request pending
- mem_addr_o  out  ADDR_W  fetch address; stable while mem_req_o=1
- mem_ack_i  in  1  memory completes the pending request this cycle
- mem_rdata_i  in  INST_W  instruction; valid when mem_ack_i=1
- branch_flag_i  in  1  redirect from ID
- branch_addr_i  in  ADDR_W  redirect target; bits [1:0] are forced to 0
- inst_valid_o  out  1  queue head valid
- inst_o  out  INST_W  head instruction; 0 when empty
- pc_o  out  ADDR_W  head PC; 0 when empty
- id_ready_i  in  1  decode accepts the head this cycle
- occupancy_o  out  $clog2(DEPTH)+1  entries in the queue

## Operation
- State machine, 3 states: IDLE (no request), REQ (request pending), DROP (request pending, response to be discarded). mem_req_o = (state != IDLE).
- fetch_pc register holds the next address to request. mem_addr_o is a register loaded on every entry to REQ.
- pop = inst_valid_o & id_ready_i & ~branch_flag_i.
- push = (state==REQ) & mem_ack_i & ~branch_flag_i. It writes {mem_addr_o, mem_rdata_i} at the tail.
- count_next = 0 on branch, else count + push − pop.
- IDLE:
  - branch: fetch_pc←branch_addr; enter REQ at branch_addr.
  - else if count_next < DEPTH: enter REQ at fetch_pc.
- REQ with ack, no branch:
  - push the entry; fetch_pc←mem_addr_o+4.
  - If count_next < DEPTH, stay in REQ at mem_addr_o+4 (back-to-back fetch). Otherwise go to IDLE.
- REQ with ack and branch in the same cycle: data is discarded, the queue is flushed, and the next request goes to branch_addr (stay in REQ).
- REQ without ack, with branch: go to DROP; fetch_pc←branch_addr. mem_addr_o is unchanged, because the address must stay stable until ack.
- DROP:
  - branch: fetch_pc←branch_addr, stay in DROP.
  - ack: discard data; enter REQ at fetch_pc, or at branch_addr if a branch arrives in the same cycle.
- Flush empties the queue (head=tail=count=0) regardless of id_ready_i. The head presented in the branch cycle is not popped.
- Address arithmetic wraps modulo 2^ADDR_W.
- No push ever occurs with count=DEPTH. The single-outstanding rule plus the count_next check guarantee this. Verification asserts it.

## Timing
- Reset values: state=IDLE, fetch_pc=RESET_PC, mem_addr_o=RESET_PC, mem_req_o=0, queue empty, inst_valid_o=0, inst_o=0, pc_o=0, occupancy_o=0.
- mem_ack_i, branch_flag_i and id_ready_i are ignored while rst=1. Reset mid-transaction drops the transaction with no further handshake.
- If rst deasserts before edge k, mem_req_o=1 from cycle k+1 with addr RESET_PC.
- Fetch-to-decode latency: a push at edge t makes the entry visible on inst_valid_o/inst_o/pc_o after edge t. There is no bypass from mem_rdata_i to inst_o.
- Throughput with zero-wait memory (ack in the same cycle as req) and id_ready_i=1: one instruction per cycle, sustained.
- Branch penalty with zero-wait memory: the new-target request starts the cycle after the branch, and its first instruction is valid one cycle later.
- Outputs inst_o, pc_o and inst_valid_o are read combinationally from queue storage and pointers. mem_req_o and mem_addr_o are driven from registers only.

## Test plan
- Reset + zero-wait memory, ack=1 always, ready=1:
  - mem_req_o rises one cycle after reset release.
  - pc_o sequence is 0,4,8,12…, one per cycle, starting two cycles after release.
  - occupancy_o never exceeds 1.
- Stall: ready=0 for 10 cycles with DEPTH=4. Required response:
  - occupancy_o saturates at 4 and mem_req_o drops to 0.
  - On ready=1, four entries drain in order (0,4,8,12) and fetching resumes at 16 with no gap beyond one cycle.
- Wait states: ack asserted 3 cycles after each request. Required response:
  - mem_addr_o is stable across each wait.
  - Entries arrive every 4 cycles with consecutive PCs.
- Branch during a wait: request at 0x20 pending, branch to 0x103 before ack. Required response:
  - State goes to DROP; the late ack data is not enqueued.
  - The next request is 0x100; the first valid pc_o after the branch is 0x100.
  - The queue is empty in the cycle after the branch.
- Same-cycle events:
  - Branch to 0x40 and ack together: the acked data is dropped and the next request is 0x40.
  - Branch and pop with a full queue: occupancy_o=0 next cycle and the pointers are reset.
- Mid-operation reset with the queue holding 3 entries and a request pending: all outputs return to reset values the next cycle, and fetching restarts at RESET_PC.
